// File: rtl/mux_seq_pkg.sv
// rtl/mux_seq_pkg.sv - shared constants, FSM state type and length clamp for the bank readout sequencer
package mux_seq_pkg;

    localparam int NUM_WORDS = 288;
    localparam int DATA_W    = 16;
    localparam int IDX_W     = 9;

    localparam logic [IDX_W:0] MAX_LEN = (IDX_W+1)'(NUM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [IDX_W:0] len;
        logic           err;
    } clamp_t;

    // Zero or oversize requests read the whole bank and flag the error.
    function automatic clamp_t clamp_len(input logic [IDX_W:0] len);
        clamp_t r;
        r.err = (len == '0) || (len > MAX_LEN);
        r.len = r.err ? MAX_LEN : len;
        return r;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// rtl/stream_out_reg.sv - single-stage valid/ready output register with load strobe and clear
import mux_seq_pkg::*;

module stream_out_reg (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              last
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            data  <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
            last  <= load_last;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mux_seq_ctrl.sv
// rtl/mux_seq_ctrl.sv - drives the bank word-select index and streams the selected words out
import mux_seq_pkg::*;

module mux_seq_ctrl (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [IDX_W:0]    len,
    output logic [IDX_W-1:0]  sel,
    input  logic [DATA_W-1:0] sel_data,
    output logic              bank_hold,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              len_err
);

    state_t         state, state_nxt;
    logic [IDX_W-1:0] sel_nxt;
    logic [IDX_W:0] cnt_len, cnt_len_nxt;
    logic           done_nxt;
    logic           len_err_nxt;
    logic           load;
    logic           clear;
    logic           at_last;
    clamp_t         clamp;

    assign clamp     = clamp_len(len);
    assign at_last   = ({1'b0, sel} == (cnt_len - (IDX_W+1)'(1)));
    assign busy      = (state != IDLE);
    assign bank_hold = busy;

    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        cnt_len_nxt = cnt_len;
        done_nxt    = 1'b0;
        len_err_nxt = 1'b0;
        load        = 1'b0;
        clear       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt   = RUN;
                    cnt_len_nxt = clamp.len;
                    len_err_nxt = clamp.err;
                    sel_nxt     = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    sel_nxt   = '0;
                    clear     = 1'b1;
                end else if (!out_valid || out_ready) begin
                    load = 1'b1;
                    // sel parks on the final index until the last word is accepted
                    if (at_last) begin
                        state_nxt = DRAIN;
                    end else begin
                        sel_nxt = sel + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    sel_nxt   = '0;
                    clear     = 1'b1;
                end else if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                    sel_nxt   = '0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= '0;
            cnt_len <= '0;
            done    <= 1'b0;
            len_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            cnt_len <= cnt_len_nxt;
            done    <= done_nxt;
            len_err <= len_err_nxt;
        end
    end

    stream_out_reg u_out (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .load      (load),
        .load_data (sel_data),
        .load_last (at_last),
        .ready     (out_ready),
        .data      (out_data),
        .valid     (out_valid),
        .last      (out_last)
    );

endmodule
